// File: rtl/ext_sync_pkg.sv
// ---------------------------------------------------------------------------
// ext_sync_pkg
// Shared definitions for the quadrature path-sensor emulator:
//   - state_e             : controller states (IDLE, RUN, SETTLE)
//   - phase_to_ab()       : 2-bit phase to {A,B} Gray lookup
//   - DP_STEP_DIV_DEFAULT : default clocks-per-step minus one
// ---------------------------------------------------------------------------
package ext_sync_pkg;

    // Slightly slower than the counter's acceptance rate of 16'h927C at 75 MHz
    localparam logic [15:0] DP_STEP_DIV_DEFAULT = 16'h9480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } state_e;

    // Phase 0..3 -> {A,B} = 00, 10, 11, 01; adjacent phases differ in one bit
    function automatic logic [1:0] phase_to_ab(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            2'd3:    ab = 2'b01;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/ext_sync_gen_div.sv
// ---------------------------------------------------------------------------
// ext_sync_gen_div
// Step-period divider. Counts 0..DIV_MAX while enabled and wraps to 0 after
// the terminal count. A clear holds the count at 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (count <= 0), has priority over en
//   en         : count enable
//   tc         : terminal count, high while enabled and count == DIV_MAX
// ---------------------------------------------------------------------------
module ext_sync_gen_div #(
    parameter logic [15:0] DIV_MAX = 16'h9480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [15:0] cnt_r;
    logic        at_max_s;

    // Terminal-count decode
    always_comb begin
        at_max_s = (cnt_r == DIV_MAX);
        tc       = en & at_max_s;
    end

    // Period counter: clear, wrap at terminal count, or advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (clr) begin
            cnt_r <= 16'd0;
        end else if (en) begin
            if (at_max_s) begin
                cnt_r <= 16'd0;
            end else begin
                cnt_r <= cnt_r + 16'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ext_sync_gen.sv
// ---------------------------------------------------------------------------
// ext_sync_gen
// Quadrature path-sensor emulator. Walks the A/B lines one Gray step per
// STEP_DIV+1 clocks toward a commanded absolute position, then holds idle
// for SETTLE_PERIODS step periods before accepting the next command.
// Ports:
//   clk, rst_n        : 75 MHz clock, asynchronous active-low reset
//   i_cmd_valid       : target command valid (accepted with o_cmd_ready)
//   i_cmd_target[31:0]: absolute target position, modulo 2^32
//   o_cmd_ready       : high only in IDLE
//   i_set_valid       : preset position (IDLE only), A/B unchanged
//   i_set_pos[31:0]   : preset value
//   i_abort           : stop motion at the next period boundary
//   o_dp_a, o_dp_b    : emulated sensor channels, registered
//   o_position[31:0]  : current emulated position
//   o_busy            : high whenever not IDLE
// ---------------------------------------------------------------------------
module ext_sync_gen
    import ext_sync_pkg::*;
#(
    parameter logic [15:0] STEP_DIV       = DP_STEP_DIV_DEFAULT,
    parameter int unsigned SETTLE_PERIODS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cmd_valid,
    input  logic [31:0] i_cmd_target,
    output logic        o_cmd_ready,
    input  logic        i_set_valid,
    input  logic [31:0] i_set_pos,
    input  logic        i_abort,
    output logic        o_dp_a,
    output logic        o_dp_b,
    output logic [31:0] o_position,
    output logic        o_busy
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_PERIODS - 1);

    state_e      state_r,  state_nxt_s;
    logic [1:0]  phase_r,  phase_nxt_s;
    logic [31:0] pos_r,    pos_nxt_s;
    logic [31:0] tgt_r,    tgt_nxt_s;
    logic [15:0] settle_r, settle_nxt_s;
    logic        abort_r,  abort_nxt_s;
    logic [1:0]  ab_r;
    logic        ready_r;
    logic        busy_r;

    logic        div_clr_s;
    logic        div_en_s;
    logic        div_tc_s;
    logic [31:0] base_pos_s;
    logic [31:0] diff_s;
    logic [31:0] step_pos_s;
    logic [1:0]  step_phase_s;

    // Divider is held at 0 in IDLE so the first step lands STEP_DIV+1 clocks after accept
    always_comb begin
        div_clr_s = (state_r == IDLE);
        div_en_s  = (state_r != IDLE);
    end

    ext_sync_gen_div #(
        .DIV_MAX (STEP_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr_s),
        .en    (div_en_s),
        .tc    (div_tc_s)
    );

    // Direction and candidate step: sign of target-position, 0x80000000 decrements
    always_comb begin
        diff_s = tgt_r - pos_r;
        if (diff_s[31]) begin
            step_pos_s   = pos_r - 32'd1;
            step_phase_s = phase_r - 2'd1;
        end else begin
            step_pos_s   = pos_r + 32'd1;
            step_phase_s = phase_r + 2'd1;
        end
    end

    // Controller next-state and datapath updates
    always_comb begin
        state_nxt_s  = state_r;
        phase_nxt_s  = phase_r;
        pos_nxt_s    = pos_r;
        tgt_nxt_s    = tgt_r;
        settle_nxt_s = settle_r;
        abort_nxt_s  = abort_r;
        base_pos_s   = pos_r;

        case (state_r)
            IDLE: begin
                abort_nxt_s  = 1'b0;
                settle_nxt_s = 16'd0;
                // A preset in the same cycle as a command is applied first
                if (i_set_valid) begin
                    base_pos_s = i_set_pos;
                end else begin
                    base_pos_s = pos_r;
                end
                pos_nxt_s = base_pos_s;
                if (i_cmd_valid) begin
                    tgt_nxt_s = i_cmd_target;
                    if (i_cmd_target == base_pos_s) begin
                        state_nxt_s = SETTLE;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            RUN: begin
                if (div_tc_s) begin
                    if (abort_r | i_abort) begin
                        state_nxt_s  = SETTLE;
                        settle_nxt_s = 16'd0;
                        abort_nxt_s  = 1'b0;
                    end else begin
                        phase_nxt_s = step_phase_s;
                        pos_nxt_s   = step_pos_s;
                        if (step_pos_s == tgt_r) begin
                            state_nxt_s  = SETTLE;
                            settle_nxt_s = 16'd0;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end
                end else begin
                    abort_nxt_s = abort_r | i_abort;
                end
            end

            SETTLE: begin
                if (div_tc_s) begin
                    if (settle_r == SETTLE_LAST) begin
                        state_nxt_s  = IDLE;
                        settle_nxt_s = 16'd0;
                    end else begin
                        settle_nxt_s = settle_r + 16'd1;
                    end
                end else begin
                    settle_nxt_s = settle_r;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; A/B follow phase on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            phase_r  <= 2'd0;
            pos_r    <= 32'd0;
            tgt_r    <= 32'd0;
            settle_r <= 16'd0;
            abort_r  <= 1'b0;
            ab_r     <= 2'b00;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            phase_r  <= phase_nxt_s;
            pos_r    <= pos_nxt_s;
            tgt_r    <= tgt_nxt_s;
            settle_r <= settle_nxt_s;
            abort_r  <= abort_nxt_s;
            ab_r     <= phase_to_ab(phase_nxt_s);
            ready_r  <= (state_nxt_s == IDLE);
            busy_r   <= (state_nxt_s != IDLE);
        end
    end

    // Output ports driven straight from registers
    always_comb begin
        o_dp_a      = ab_r[1];
        o_dp_b      = ab_r[0];
        o_position  = pos_r;
        o_cmd_ready = ready_r;
        o_busy      = busy_r;
    end

endmodule
